// File: rtl/i2c_cfg_pkg.sv
// Shared configuration for the I2C codec-setup path.
// Holds the I2C word width, the WM8731 device address and register words,
// pad pull constants, the sequencer state encoding and a width helper.
`ifndef I2C_DATA_WIDTH
`define I2C_DATA_WIDTH 24
`endif
`ifndef I2C_ADDR
`define I2C_ADDR 8'h34
`endif
`ifndef PULLUP
`define PULLUP 1'b1
`endif
`ifndef PULLDOWN
`define PULLDOWN 1'b0
`endif

package i2c_cfg_pkg;

  localparam int         I2C_DATA_WIDTH = `I2C_DATA_WIDTH;
  localparam logic [7:0] I2C_ADDR       = `I2C_ADDR;
  localparam logic       PULLUP         = `PULLUP;
  localparam logic       PULLDOWN       = `PULLDOWN;

  // WM8731 register words: {7-bit register address, 9-bit value}.
  localparam logic [15:0] WM_RESET   = 16'h1E00;
  localparam logic [15:0] WM_LLINE   = 16'h0017;
  localparam logic [15:0] WM_RLINE   = 16'h0217;
  localparam logic [15:0] WM_LHP     = 16'h0479;
  localparam logic [15:0] WM_RHP     = 16'h0679;
  localparam logic [15:0] WM_ANALOG  = 16'h0812;
  localparam logic [15:0] WM_DIGITAL = 16'h0A06;
  localparam logic [15:0] WM_POWER   = 16'h0C00;
  localparam logic [15:0] WM_FORMAT  = 16'h0E01;
  localparam logic [15:0] WM_SAMPLE  = 16'h1002;
  localparam logic [15:0] WM_ACTIVE  = 16'h1201;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } seq_state_e;

  // $clog2 that never returns 0, so single-entry counters still get one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wm8731_reg_rom.sv
// WM8731 power-up register table.
// Ports:
//   idx_i  - table index
//   data_o - {I2C_ADDR, register word}; out-of-range indices return the reset word
module wm8731_reg_rom
  import i2c_cfg_pkg::*;
#(
  parameter  int NUM_REGS = 11,
  localparam int IDX_W    = clog2_min1(NUM_REGS)
) (
  input  logic [IDX_W-1:0]          idx_i,
  output logic [I2C_DATA_WIDTH-1:0] data_o
);

  logic [15:0] reg_word;

  always_comb begin
    // NOTE: the default before the case keeps every path assigned, so no latch is inferred.
    reg_word = WM_RESET;
    case (int'(idx_i))
      0:       reg_word = WM_RESET;
      1:       reg_word = WM_LLINE;
      2:       reg_word = WM_RLINE;
      3:       reg_word = WM_LHP;
      4:       reg_word = WM_RHP;
      5:       reg_word = WM_ANALOG;
      6:       reg_word = WM_DIGITAL;
      7:       reg_word = WM_POWER;
      8:       reg_word = WM_FORMAT;
      9:       reg_word = WM_SAMPLE;
      10:      reg_word = WM_ACTIVE;
      default: reg_word = WM_RESET;
    endcase
  end

  assign data_o = {I2C_ADDR, reg_word};

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Walks a table of NUM_REGS I2C write words and hands each one to an I2C
// controller through a start/done/ack handshake, with bounded retries, a
// per-transfer timeout, an inter-attempt gap and error reporting.
// Ports:
//   clk_i, rst_i          - clock, asynchronous active-high reset
//   start_i               - run request (honoured in IDLE/DONE/ERROR)
//   tbl_idx_o/tbl_data_i  - table lookup (data is combinational from idx)
//   i2c_data_o/start_o    - word and one-cycle request to the controller
//   i2c_done_i/ack_i      - controller completion pulse and ack status
//   busy_o/done_o/err_o   - run status; done/err hold until the next run
//   err_idx_o             - failing entry while err_o is high
//   retry_cnt_o           - failed attempts on the current entry
module i2c_reg_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter  int NUM_REGS       = 11,
  parameter  int DATA_WIDTH     = I2C_DATA_WIDTH,
  parameter  int MAX_RETRIES    = 3,
  parameter  int TIMEOUT_CYCLES = 65535,
  parameter  int GAP_CYCLES     = 16,
  parameter  bit AUTO_START     = 1'b1,
  localparam int IDX_W          = clog2_min1(NUM_REGS),
  localparam int RTY_W          = clog2_min1(MAX_RETRIES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic [IDX_W-1:0]      tbl_idx_o,
  input  logic [DATA_WIDTH-1:0] tbl_data_i,
  output logic [DATA_WIDTH-1:0] i2c_data_o,
  output logic                  i2c_start_o,
  input  logic                  i2c_done_i,
  input  logic                  i2c_ack_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [IDX_W-1:0]      err_idx_o,
  output logic [RTY_W-1:0]      retry_cnt_o
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = clog2_min1(GAP_CYCLES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_SAT  = {TMO_W{1'b1}};
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // With no gap configured, the next attempt loads immediately.
  localparam seq_state_e AFTER_ATTEMPT = (GAP_CYCLES == 0) ? ST_LOAD : ST_GAP;

  seq_state_e            state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      err_idx_q;
  logic [RTY_W-1:0]      rty_q;
  logic [TMO_W-1:0]      tmo_q;
  logic [GAP_W-1:0]      gap_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  start_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic                  auto_q;   // one-shot run request on the first clock after reset

  logic run_req;
  assign run_req = start_i | auto_q;

  // NOTE: asynchronous reset in the sensitivity list, and non-blocking assignments
  // for all state so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      err_idx_q <= '0;
      rty_q     <= '0;
      tmo_q     <= '0;
      gap_q     <= '0;
      data_q    <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      auto_q    <= AUTO_START;
    end else begin
      auto_q  <= 1'b0;
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (run_req) begin
            idx_q   <= '0;
            rty_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          data_q  <= tbl_data_i;
          start_q <= 1'b1;          // high for exactly the START cycle
          state_q <= ST_START;
        end
        ST_START: begin
          tmo_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          gap_q <= '0;
          // Done is tested first so it wins over a coincident timeout.
          if (i2c_done_i && i2c_ack_i) begin
            rty_q <= '0;
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= AFTER_ATTEMPT;
            end
          end else if (i2c_done_i || (tmo_q == TMO_LAST)) begin
            if (rty_q == RTY_MAX) begin
              err_q     <= 1'b1;
              err_idx_q <= idx_q;
              busy_q    <= 1'b0;
              state_q   <= ST_ERROR;
            end else begin
              rty_q   <= rty_q + RTY_W'(1);
              state_q <= AFTER_ATTEMPT;
            end
          end else if (tmo_q != TMO_SAT) begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= ST_LOAD;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tbl_idx_o   = idx_q;
  assign i2c_data_o  = data_q;
  assign i2c_start_o = start_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_idx_o   = err_idx_q;
  assign retry_cnt_o = rty_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer with the WM8731 ROM beside it and a
// behavioural I2C controller that answers each start pulse after a
// programmable latency, optionally NACKing or never answering one entry.
module tb_i2c_reg_sequencer;

  localparam int NREG = 11;
  localparam int GAP  = 4;
  localparam int TMO  = 100;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [3:0]  tbl_idx;
  logic [23:0] tbl_data;
  logic [23:0] i2c_data;
  logic        i2c_start;
  logic        i2c_done;
  logic        i2c_ack;
  logic        busy, done, err;
  logic [3:0]  err_idx;
  logic [1:0]  retry_cnt;

  always #5 clk = ~clk;

  wm8731_reg_rom #(.NUM_REGS(NREG)) u_rom (
    .idx_i  (tbl_idx),
    .data_o (tbl_data)
  );

  i2c_reg_sequencer #(
    .NUM_REGS       (NREG),
    .DATA_WIDTH     (24),
    .MAX_RETRIES    (3),
    .TIMEOUT_CYCLES (TMO),
    .GAP_CYCLES     (GAP),
    .AUTO_START     (1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .tbl_idx_o   (tbl_idx),
    .tbl_data_i  (tbl_data),
    .i2c_data_o  (i2c_data),
    .i2c_start_o (i2c_start),
    .i2c_done_i  (i2c_done),
    .i2c_ack_i   (i2c_ack),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .err_idx_o   (err_idx),
    .retry_cnt_o (retry_cnt)
  );

  // Hand-computed {0x34, register word} table.
  logic [23:0] exp_rom [NREG] = '{
    24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679, 24'h340812,
    24'h340A06, 24'h340C00, 24'h340E01, 24'h341002, 24'h341201
  };

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Controller model configuration.
  int lat_ok   = 40;
  int bad_idx  = -1;
  int bad_left = 0;
  int bad_mode = 0;   // 0: NACK, 1: never done, 2: ACK after bad_lat
  int bad_lat  = 0;
  int pend     = 0;
  logic pend_ack = 1'b0;

  // Log of observed start pulses.
  logic [23:0] st_data [$];
  int          st_cyc  [$];
  int          st_rty  [$];

  function automatic int rom_index(input logic [23:0] w);
    for (int i = 0; i < NREG; i++) if (exp_rom[i] == w) return i;
    return -1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    i2c_done = 1'b0;
    i2c_ack  = 1'b0;
    forever begin
      @(negedge clk);
      i2c_done = 1'b0;
      i2c_ack  = 1'b0;
      if (rst_i) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            i2c_done = 1'b1;
            i2c_ack  = pend_ack;
          end
        end
        if (i2c_start) begin
          st_data.push_back(i2c_data);
          st_cyc.push_back(cyc);
          st_rty.push_back(int'(retry_cnt));
          if (rom_index(i2c_data) == bad_idx && bad_left > 0) begin
            bad_left--;
            case (bad_mode)
              0:       begin pend = lat_ok;  pend_ack = 1'b0; end
              1:       pend = 0;
              default: begin pend = bad_lat; pend_ack = 1'b1; end
            endcase
          end else begin
            pend     = lat_ok;
            pend_ack = 1'b1;
          end
        end
      end
    end
  end

  task automatic clear_log();
    st_data.delete();
    st_cyc.delete();
    st_rty.delete();
  endtask

  task automatic start_run();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit expired);
    expired = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done || err) begin
        expired = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_run_end(input string name, input int budget);
    bit expired;
    wait_end(budget, expired);
    n_vec++;
    if (expired) begin
      n_err++;
      $display("FAIL %s end-of-run: no done/err within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    rst_i   = 1'b1;
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({i2c_start, busy, done, err} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0000", {i2c_start, busy, done, err});
    end
    n_vec++;
    if ({tbl_idx, err_idx, retry_cnt} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_counters: idx=%0d err_idx=%0d rty=%0d want 0", tbl_idx, err_idx, retry_cnt);
    end
    n_vec++;
    if (i2c_data !== 24'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 000000", i2c_data);
    end
    clear_log();
    rst_i = 1'b0;
  endtask

  task automatic test_happy_path();
    check_run_end("happy", 3000);
    n_vec++;
    if (st_data.size() != NREG) begin
      n_err++;
      $display("FAIL happy_count: got %0d starts want %0d", st_data.size(), NREG);
    end else begin
      for (int i = 0; i < NREG; i++) begin
        n_vec++;
        if (st_data[i] !== exp_rom[i]) begin
          n_err++;
          $display("FAIL happy_word[%0d]: got %h want %h", i, st_data[i], exp_rom[i]);
        end
      end
    end
    n_vec++;
    if ({done, busy, err} !== 3'b100) begin
      n_err++;
      $display("FAIL happy_status: done/busy/err=%b want 100", {done, busy, err});
    end
  endtask

  // Re-run from DONE with start latency checks, a busy-time start pulse,
  // and entry 3 NACKed twice before it is acked.
  task automatic test_nack_recover();
    int exp_seq [13] = '{0, 1, 2, 3, 3, 3, 4, 5, 6, 7, 8, 9, 10};
    clear_log();
    bad_idx = 3; bad_left = 2; bad_mode = 0;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n_vec++;
    if ({done, busy, i2c_start} !== 3'b010 || tbl_idx !== 4'd0) begin
      n_err++;
      $display("FAIL rerun_load: done/busy/start=%b idx=%0d want 010 idx 0", {done, busy, i2c_start}, tbl_idx);
    end
    @(negedge clk);
    n_vec++;
    if (i2c_start !== 1'b1 || i2c_data !== exp_rom[0]) begin
      n_err++;
      $display("FAIL start_latency: start=%b data=%h want 1 %h", i2c_start, i2c_data, exp_rom[0]);
    end
    repeat (100) @(negedge clk);
    start_i = 1'b1;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_mid_run: got %b want 1", busy);
    end
    @(negedge clk);
    start_i = 1'b0;
    check_run_end("nack", 3000);
    n_vec++;
    if (st_data.size() != 13) begin
      n_err++;
      $display("FAIL nack_count: got %0d starts want 13", st_data.size());
    end else begin
      for (int i = 0; i < 13; i++) begin
        n_vec++;
        if (st_data[i] !== exp_rom[exp_seq[i]]) begin
          n_err++;
          $display("FAIL nack_word[%0d]: got %h want %h", i, st_data[i], exp_rom[exp_seq[i]]);
        end
      end
      n_vec++;
      if (st_rty[4] != 1 || st_rty[5] != 2 || st_rty[6] != 0) begin
        n_err++;
        $display("FAIL nack_retry_cnt: got %0d,%0d,%0d want 1,2,0", st_rty[4], st_rty[5], st_rty[6]);
      end
    end
    n_vec++;
    if ({done, busy, err} !== 3'b100) begin
      n_err++;
      $display("FAIL nack_status: done/busy/err=%b want 100", {done, busy, err});
    end
  endtask

  task automatic test_retries_exhausted();
    clear_log();
    bad_idx = 5; bad_left = 99; bad_mode = 0;
    start_run();
    check_run_end("exhaust", 3000);
    repeat (60) @(negedge clk);
    n_vec++;
    if (st_data.size() != 9) begin
      n_err++;
      $display("FAIL exhaust_count: got %0d starts want 9", st_data.size());
    end else begin
      for (int i = 5; i < 9; i++) begin
        n_vec++;
        if (st_data[i] !== exp_rom[5]) begin
          n_err++;
          $display("FAIL exhaust_word[%0d]: got %h want %h", i, st_data[i], exp_rom[5]);
        end
      end
    end
    n_vec++;
    if ({err, done, busy} !== 3'b100 || err_idx !== 4'd5) begin
      n_err++;
      $display("FAIL exhaust_status: err/done/busy=%b err_idx=%0d want 100 idx 5", {err, done, busy}, err_idx);
    end
  endtask

  task automatic test_timeout();
    clear_log();
    bad_idx = 0; bad_left = 99; bad_mode = 1;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n_vec++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL rerun_from_error: err=%b busy=%b want 0 1", err, busy);
    end
    check_run_end("timeout", 1500);
    n_vec++;
    if (st_data.size() != 4) begin
      n_err++;
      $display("FAIL timeout_count: got %0d starts want 4", st_data.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        n_vec++;
        if (st_cyc[i] - st_cyc[i-1] != TMO + GAP + 2 || st_data[i] !== exp_rom[0]) begin
          n_err++;
          $display("FAIL timeout_spacing[%0d]: got %0d cycles data %h want %0d %h",
                   i, st_cyc[i] - st_cyc[i-1], st_data[i], TMO + GAP + 2, exp_rom[0]);
        end
      end
    end
    n_vec++;
    if (err !== 1'b1 || err_idx !== 4'd0) begin
      n_err++;
      $display("FAIL timeout_status: err=%b err_idx=%0d want 1 0", err, err_idx);
    end
  endtask

  // Done on the last WAIT cycle succeeds; one cycle later it is a timeout.
  task automatic test_done_boundary();
    clear_log();
    bad_idx = 2; bad_left = 1; bad_mode = 2; bad_lat = TMO;
    start_run();
    check_run_end("edge_ok", 3000);
    n_vec++;
    if (st_data.size() != NREG || done !== 1'b1) begin
      n_err++;
      $display("FAIL done_at_last_wait: starts=%0d done=%b want %0d 1", st_data.size(), done, NREG);
    end
    clear_log();
    bad_left = 1; bad_lat = TMO + 1;
    start_run();
    check_run_end("edge_late", 3000);
    n_vec++;
    if (st_data.size() != NREG + 1 || done !== 1'b1) begin
      n_err++;
      $display("FAIL done_after_timeout: starts=%0d done=%b want %0d 1", st_data.size(), done, NREG + 1);
    end else begin
      n_vec++;
      if (st_data[3] !== exp_rom[2] || st_rty[3] != 1 || st_data[4] !== exp_rom[3]) begin
        n_err++;
        $display("FAIL late_retry: data=%h rty=%0d next=%h want %h 1 %h",
                 st_data[3], st_rty[3], st_data[4], exp_rom[2], exp_rom[3]);
      end
    end
  endtask

  task automatic test_reset_mid_transfer();
    bit seen;
    clear_log();
    bad_idx = -1; bad_left = 0;
    start_run();
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (st_data.size() >= 8) begin
        seen = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL reach_entry7: got %0d starts want 8", st_data.size());
    end
    repeat (10) @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    n_vec++;
    if ({i2c_start, busy, done, err} !== 4'b0000 || i2c_data !== 24'h0 ||
        {tbl_idx, err_idx, retry_cnt} !== 10'd0) begin
      n_err++;
      $display("FAIL async_reset: flags=%b data=%h idx=%0d err_idx=%0d rty=%0d want all 0",
               {i2c_start, busy, done, err}, i2c_data, tbl_idx, err_idx, retry_cnt);
    end
    @(negedge clk);
    clear_log();
    @(negedge clk);
    rst_i = 1'b0;
    check_run_end("auto_restart", 3000);
    n_vec++;
    if (st_data.size() != NREG || st_data[0] !== exp_rom[0] || done !== 1'b1) begin
      n_err++;
      $display("FAIL auto_restart: starts=%0d first=%h done=%b want %0d %h 1",
               st_data.size(), (st_data.size() > 0) ? st_data[0] : 24'hx, done, NREG, exp_rom[0]);
    end
  endtask

  initial begin
    test_reset();
    test_happy_path();
    test_nack_recover();
    test_retries_exhausted();
    test_timeout();
    test_done_boundary();
    test_reset_mid_transfer();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
